sub2_drv: RTL and testbench
===========================

# sub2_drv

Stimulus-and-check driver for the `sub2` port set. It drives `sub2`'s inputs (`sig_e`..`sig_h`) with a deterministic beat sequence and captures its outputs (`sig_i`..`sig_l`) on the return path. Each returned beat is compared against the value it drove `LAT` cycles earlier, and mismatching beats are counted. It sits opposite `sub2` in loopback/bring-up builds, where the return path is expected to echo e→i, f→j, g→k, h→l.

## Interface
- `NBEATS`, default 4: beats per sequence; range 1..1023.
- `LAT`, default 1: round-trip latency in cycles from driven beat to returned beat; range 1..8. `LAT=0` is not supported.
- `i_clk`, input, 1: clock.
- `i_rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `i_start`, input, 1: start pulse. Honoured only in IDLE.
- `i_seed`, input, [7:0]: data base value, sampled when start is accepted.
- `o_sig_e`, output, 1: single signal to `sub2`.
- `o_sig_f`, output, [1:0]: vector to `sub2`.
- `o_sig_g`, output, [0:2][7:0]: packed 2D array to `sub2`.
- `o_sig_h`, output, [7:0] x [0:2]: unpacked 2D array to `sub2`.
- `i_sig_i`, input, 1: returned single signal.
- `i_sig_j`, input, [1:0]: returned vector.
- `i_sig_k`, input, [0:2][7:0]: returned packed array.
- `i_sig_l`, input, [7:0] x [0:2]: returned unpacked array.
- `o_busy`, output, 1: high in DRIVE and DRAIN.
- `o_done`, output, 1: one-cycle pulse at sequence end.
- `o_err_cnt`, output, [7:0]: count of mismatching beats. Saturates at 255.

## Operation
- **States:**
  - IDLE →(`i_start`)→ DRIVE.
  - DRIVE →(after beat `NBEATS-1`)→ DRAIN.
  - DRAIN →(after `LAT` cycles)→ DONE.
  - DONE →(always)→ IDLE.
- **Accepted start:** latches `i_seed` into `seed`, clears the beat counter `b`, clears `o_err_cnt`. `i_start` in any other state is ignored.
- **Beat `b` values in DRIVE** (all arithmetic mod 256):
  - `e = ~b[0]`
  - `f = b[1:0]`
  - `g[n] = seed + 3*b + n` for n = 0..2
  - `h[n] = ~g[n]`
- **Outputs outside DRIVE:** all `o_sig_*` = 0. All outputs are registered.
- **Expected-value pipeline:** depth `LAT`, entries {valid, e, f, g, h}. A valid entry is pushed each DRIVE cycle; an invalid entry is pushed otherwise.
- **Compare:** when the pipeline head is valid, sample `i_sig_*`. If any bit of i/j/k/l differs from the expected e/f/g/h, increment `o_err_cnt` by 1, saturating at 255 (no wrap). At most one increment per beat.
- **Reset (async, any time, including mid-sequence):**
  - State → IDLE.
  - `b`, `seed`, pipeline valid bits → 0.
  - Every output → 0: `o_sig_*`, `o_busy`, `o_done`, `o_err_cnt`.

## Timing
- Start sampled high at the edge ending cycle t → beat b is driven during cycle t+1+b, for b = 0..NBEATS-1.
- Returned beat b must be present on `i_sig_*` during cycle t+1+b+LAT. It is sampled at the edge ending that cycle.
- DRAIN occupies cycles t+1+NBEATS .. t+NBEATS+LAT.
- DONE is cycle t+NBEATS+LAT+1:
  - `o_done` = 1 and `o_busy` = 0.
  - `o_err_cnt` is final and already includes the last beat's compare.
- `o_err_cnt` holds its value through IDLE until the next accepted start.
- Earliest restart: `i_start` in the cycle after DONE (back in IDLE).
- `i_start` high during DONE is ignored.
- Sequence length start-to-done: NBEATS+LAT+1 cycles.

## Test plan
- **Clean loopback:** `LAT`=1, `NBEATS`=4, registered echo path, `i_seed`=0x10, start at cycle 0.
  - Beats on cycles 1..4: `o_sig_g` = {10,11,12}, {13,14,15}, {16,17,18}, {19,1A,1B}; `o_sig_f` = 0,1,2,3; `o_sig_e` = 1,0,1,0.
  - `o_done` at cycle 6 with `o_err_cnt` = 0.
- **Error injection:** `LAT`=3, 3-stage echo, flip `i_sig_l[2]` bit 0 on beat 2 only → `o_err_cnt` = 1 at `o_done`. Also corrupt `i_sig_i` on the same beat → still 1, since the count is per beat, not per field.
- **Saturation:** `NBEATS`=300, return path tied to 0 → `o_err_cnt` reaches 255 and holds. `o_done` at cycle 300+LAT+1.
- **Start while busy:** pulse `i_start` during DRIVE and during DONE → no restart. Sequence length unchanged, `o_err_cnt` not cleared.
- **Reset mid-sequence:** assert `i_rst_n`=0 during beat 2 (asynchronous, between edges).
  - All outputs read 0 immediately.
  - After release, no `o_done` without a new start.
  - A fresh start runs a clean sequence with `o_err_cnt` = 0.

Source files
------------

// File: rtl/sub2_drv.sv
// sub2_drv: beat-sequence driver and loopback checker for the sub2 port set.
// Drives a deterministic sequence on o_sig_e..h, delays a copy of every
// driven beat by LAT cycles and compares it with what comes back on
// i_sig_i..l, counting mismatching beats (saturating at 255).
module sub2_drv #(
  parameter int NBEATS = 4,
  parameter int LAT    = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [7:0]      i_seed,
  output logic            o_sig_e,
  output logic [1:0]      o_sig_f,
  output logic [0:2][7:0] o_sig_g,
  output logic [7:0]      o_sig_h [0:2],
  input  logic            i_sig_i,
  input  logic [1:0]      i_sig_j,
  input  logic [0:2][7:0] i_sig_k,
  input  logic [7:0]      i_sig_l [0:2],
  output logic            o_busy,
  output logic            o_done,
  output logic [7:0]      o_err_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int BW = 10;  // beat index, NBEATS <= 1023
  localparam int CW = 4;   // drain counter, LAT <= 8

  localparam logic [BW-1:0] LAST_BEAT  = BW'(NBEATS - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(LAT - 1);

  // g[n] = seed + 3*b + n, everything mod 256
  function automatic logic [0:2][7:0] beat_g(input logic [7:0] seed, input logic [7:0] b);
    logic [0:2][7:0] g;
    logic [7:0]      base;
    base = seed + b * 8'd3;
    for (int n = 0; n < 3; n++) g[n] = base + 8'(n);
    return g;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [1:0]      r_state;
  logic [BW-1:0]   r_b;
  logic [CW-1:0]   r_drain;
  logic [7:0]      r_seed;

  logic            w_start_ok;
  logic            w_load;
  logic [7:0]      w_seed;
  logic [BW-1:0]   w_nb;
  logic [0:2][7:0] w_g;
  logic            w_mis;

  // Expected-value pipeline; index LAT-1 is the head being compared.
  logic            r_vld_p [0:LAT-1];
  logic            r_e_p   [0:LAT-1];
  logic [1:0]      r_f_p   [0:LAT-1];
  logic [0:2][7:0] r_g_p   [0:LAT-1];
  logic [0:2][7:0] r_h_p   [0:LAT-1];

  // Pick the beat that will be on the outputs next cycle (start or advance).
  always_comb begin
    w_start_ok = (r_state == S_IDLE) && i_start;
    w_load     = 1'b0;
    w_seed     = r_seed;
    w_nb       = '0;
    if (w_start_ok) begin
      w_load = 1'b1;
      w_seed = i_seed;
    end else if ((r_state == S_DRIVE) && (r_b != LAST_BEAT)) begin
      w_load = 1'b1;
      w_nb   = r_b + BW'(1);
    end
    w_g = beat_g(w_seed, w_nb[7:0]);
  end

  // Register the driven beat; zero whenever no beat is being driven.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sig_e <= 1'b0;
      o_sig_f <= 2'd0;
      o_sig_g <= '0;
      for (int n = 0; n < 3; n++) o_sig_h[n] <= 8'd0;
    end else begin
      o_sig_e <= w_load & ~w_nb[0];
      o_sig_f <= w_load ? w_nb[1:0] : 2'd0;
      o_sig_g <= w_load ? w_g : '0;
      for (int n = 0; n < 3; n++) o_sig_h[n] <= w_load ? ~w_g[n] : 8'd0;
    end
  end

  // Sequence FSM, beat/drain counters, busy/done flags and error counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_b       <= '0;
      r_drain   <= '0;
      r_seed    <= 8'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err_cnt <= 8'd0;
    end else begin
      if (w_start_ok) o_err_cnt <= 8'd0;
      else if (r_vld_p[LAT-1] && w_mis) o_err_cnt <= sat_inc(o_err_cnt);

      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_state <= S_DRIVE;
            r_seed  <= i_seed;
            r_b     <= '0;
            o_busy  <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (r_b == LAST_BEAT) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end else begin
            r_b <= w_nb;
          end
        end
        S_DRAIN: begin
          if (r_drain == LAST_DRAIN) begin
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

  // Valid bits of the expected pipeline: set for each cycle a beat is on the outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < LAT; k++) r_vld_p[k] <= 1'b0;
    end else begin
      r_vld_p[0] <= (r_state == S_DRIVE);
      for (int k = 1; k < LAT; k++) r_vld_p[k] <= r_vld_p[k-1];
    end
  end

  // Data of the expected pipeline, copied from the registered outputs.
  always_ff @(posedge i_clk) begin
    r_e_p[0] <= o_sig_e;
    r_f_p[0] <= o_sig_f;
    r_g_p[0] <= o_sig_g;
    r_h_p[0] <= {o_sig_h[0], o_sig_h[1], o_sig_h[2]};
    for (int k = 1; k < LAT; k++) begin
      r_e_p[k] <= r_e_p[k-1];
      r_f_p[k] <= r_f_p[k-1];
      r_g_p[k] <= r_g_p[k-1];
      r_h_p[k] <= r_h_p[k-1];
    end
  end

  // Any differing bit in any returned field makes the whole beat a mismatch.
  always_comb begin
    w_mis = (i_sig_i != r_e_p[LAT-1]) ||
            (i_sig_j != r_f_p[LAT-1]) ||
            (i_sig_k != r_g_p[LAT-1]);
    for (int n = 0; n < 3; n++) begin
      if (i_sig_l[n] != r_h_p[LAT-1][n]) w_mis = 1'b1;
    end
  end

endmodule

// File: tb/tb_sub2_drv.sv
// Bench for sub2_drv: three instances (clean echo, 3-stage echo with fault
// injection, return path tied low). Expected beats and done events are queued
// by the stimulus process and checked by independent monitors.
`timescale 1ns/1ps
module tb_sub2_drv;

  typedef struct {
    int              cyc;
    logic            e;
    logic [1:0]      f;
    logic [0:2][7:0] g;
  } beat_t;

  typedef struct {
    int cyc;
    int err;
  } done_t;

  logic clk;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  beat_t qa[$];
  done_t qda[$];
  done_t qdb[$];
  done_t qdc[$];

  // ---------------- DUT A: NBEATS=4, LAT=1, registered echo
  logic rst_a_n, start_a;
  logic [7:0] seed_a;
  logic a_e; logic [1:0] a_f; logic [0:2][7:0] a_g; logic [7:0] a_h [0:2];
  logic ea_i; logic [1:0] ea_j; logic [0:2][7:0] ea_k; logic [7:0] ea_l [0:2];
  logic a_busy, a_done; logic [7:0] a_err;

  sub2_drv #(.NBEATS(4), .LAT(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .i_start(start_a), .i_seed(seed_a),
    .o_sig_e(a_e), .o_sig_f(a_f), .o_sig_g(a_g), .o_sig_h(a_h),
    .i_sig_i(ea_i), .i_sig_j(ea_j), .i_sig_k(ea_k), .i_sig_l(ea_l),
    .o_busy(a_busy), .o_done(a_done), .o_err_cnt(a_err)
  );

  always @(posedge clk) begin
    ea_i <= a_e; ea_j <= a_f; ea_k <= a_g; ea_l <= a_h;
  end

  // ---------------- DUT B: NBEATS=4, LAT=3, 3-stage echo with injection
  logic rst_bc_n, start_b, inj;
  logic [7:0] seed_b;
  logic b_e; logic [1:0] b_f; logic [0:2][7:0] b_g; logic [7:0] b_h [0:2];
  logic b1_i, b2_i, b3_i;
  logic [1:0] b1_j, b2_j, b3_j;
  logic [0:2][7:0] b1_k, b2_k, b3_k;
  logic [7:0] b1_l [0:2]; logic [7:0] b2_l [0:2]; logic [7:0] b3_l [0:2];
  logic b_busy, b_done; logic [7:0] b_err;
  logic hit_b;

  sub2_drv #(.NBEATS(4), .LAT(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_bc_n), .i_start(start_b), .i_seed(seed_b),
    .o_sig_e(b_e), .o_sig_f(b_f), .o_sig_g(b_g), .o_sig_h(b_h),
    .i_sig_i(b3_i), .i_sig_j(b3_j), .i_sig_k(b3_k), .i_sig_l(b3_l),
    .o_busy(b_busy), .o_done(b_done), .o_err_cnt(b_err)
  );

  assign hit_b = inj && b_busy && (b_f == 2'd2);

  always @(posedge clk) begin
    b1_i <= b_e ^ hit_b; b1_j <= b_f; b1_k <= b_g;
    b1_l[0] <= b_h[0]; b1_l[1] <= b_h[1]; b1_l[2] <= b_h[2] ^ {7'd0, hit_b};
    b2_i <= b1_i; b2_j <= b1_j; b2_k <= b1_k; b2_l <= b1_l;
    b3_i <= b2_i; b3_j <= b2_j; b3_k <= b2_k; b3_l <= b2_l;
  end

  // ---------------- DUT C: NBEATS=300, LAT=1, return tied to zero
  logic start_c;
  logic [7:0] seed_c;
  logic c_e; logic [1:0] c_f; logic [0:2][7:0] c_g; logic [7:0] c_h [0:2];
  logic [0:2][7:0] zk; logic [7:0] zl [0:2];
  logic c_busy, c_done; logic [7:0] c_err;

  sub2_drv #(.NBEATS(300), .LAT(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_bc_n), .i_start(start_c), .i_seed(seed_c),
    .o_sig_e(c_e), .o_sig_f(c_f), .o_sig_g(c_g), .o_sig_h(c_h),
    .i_sig_i(1'b0), .i_sig_j(2'd0), .i_sig_k(zk), .i_sig_l(zl),
    .o_busy(c_busy), .o_done(c_done), .o_err_cnt(c_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cyc=%0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_beats(input logic [7:0] seed, input int t0, input int nb);
    beat_t x;
    logic [9:0] bb;
    for (int b = 0; b < nb; b++) begin
      bb = 10'(b);
      x.cyc = t0 + 1 + b;
      x.e = ~bb[0];
      x.f = bb[1:0];
      for (int n = 0; n < 3; n++) x.g[n] = seed + 8'(3 * b) + 8'(n);
      qa.push_back(x);
    end
  endtask

  task automatic push_done(input int which, input int c, input int err);
    done_t d;
    d.cyc = c;
    d.err = err;
    if (which == 0) qda.push_back(d);
    else if (which == 1) qdb.push_back(d);
    else qdc.push_back(d);
  endtask

  // Beat monitor for DUT A
  beat_t ba;
  always @(negedge clk) begin
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      ba = qa.pop_front();
      total++;
      if (a_e !== ba.e || a_f !== ba.f || a_g !== ba.g ||
          {a_h[0], a_h[1], a_h[2]} !== ~ba.g) begin
        bad++;
        $display("FAIL beatA cyc=%0d: got e=%0b f=%0d g=%h h=%h%h%h expected e=%0b f=%0d g=%h h=%h",
                 cyc, a_e, a_f, a_g, a_h[0], a_h[1], a_h[2], ba.e, ba.f, ba.g, ~ba.g);
      end
    end
  end

  // Done monitors: every o_done pulse must match a queued expectation
  done_t da, db, dc;
  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      total++;
      if (qda.size() == 0) begin
        bad++;
        $display("FAIL doneA: unexpected o_done at cyc=%0d err=%0d", cyc, a_err);
      end else begin
        da = qda.pop_front();
        if (cyc != da.cyc || int'(a_err) != da.err || a_busy !== 1'b0) begin
          bad++;
          $display("FAIL doneA: got cyc=%0d err=%0d busy=%0b expected cyc=%0d err=%0d busy=0",
                   cyc, a_err, a_busy, da.cyc, da.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_done === 1'b1) begin
      total++;
      if (qdb.size() == 0) begin
        bad++;
        $display("FAIL doneB: unexpected o_done at cyc=%0d err=%0d", cyc, b_err);
      end else begin
        db = qdb.pop_front();
        if (cyc != db.cyc || int'(b_err) != db.err || b_busy !== 1'b0) begin
          bad++;
          $display("FAIL doneB: got cyc=%0d err=%0d busy=%0b expected cyc=%0d err=%0d busy=0",
                   cyc, b_err, b_busy, db.cyc, db.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (c_done === 1'b1) begin
      total++;
      if (qdc.size() == 0) begin
        bad++;
        $display("FAIL doneC: unexpected o_done at cyc=%0d err=%0d", cyc, c_err);
      end else begin
        dc = qdc.pop_front();
        if (cyc != dc.cyc || int'(c_err) != dc.err || c_busy !== 1'b0) begin
          bad++;
          $display("FAIL doneC: got cyc=%0d err=%0d busy=%0b expected cyc=%0d err=%0d busy=0",
                   cyc, c_err, c_busy, dc.cyc, dc.err);
        end
      end
    end
  end

  // Hand-computed beats for seed 0x10
  logic [23:0] gtab [0:3];
  logic        etab [0:3];
  beat_t       xb;
  int          t;

  initial begin
    gtab[0] = 24'h101112; gtab[1] = 24'h131415; gtab[2] = 24'h161718; gtab[3] = 24'h191A1B;
    etab[0] = 1'b1; etab[1] = 1'b0; etab[2] = 1'b1; etab[3] = 1'b0;
    zk = '0;
    for (int n = 0; n < 3; n++) zl[n] = 8'd0;
    rst_a_n = 1'b0; rst_bc_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; inj = 1'b0;
    seed_a = 8'd0; seed_b = 8'd0; seed_c = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_e", a_e, 0);
    check("rst_f", a_f, 0);
    check("rst_g", a_g, 0);
    check("rst_h", {a_h[0], a_h[1], a_h[2]}, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    rst_a_n = 1'b1; rst_bc_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean loopback, seed 0x10
    t = cyc;
    for (int b = 0; b < 4; b++) begin
      xb.cyc = t + 1 + b; xb.e = etab[b]; xb.f = 2'(b); xb.g = gtab[b];
      qa.push_back(xb);
    end
    push_done(0, t + 6, 0);
    seed_a = 8'h10; start_a = 1'b1;
    wait_cyc(t + 1); start_a = 1'b0;
    wait_cyc(t + 9);

    // Start pulses during DRIVE and DONE are ignored; seed wraps past 0xFF
    t = cyc;
    push_beats(8'hFE, t, 4);
    push_done(0, t + 6, 0);
    seed_a = 8'hFE; start_a = 1'b1;
    wait_cyc(t + 1); start_a = 1'b0; seed_a = 8'h55;
    wait_cyc(t + 2); start_a = 1'b1;
    wait_cyc(t + 3); start_a = 1'b0;
    wait_cyc(t + 6); start_a = 1'b1;
    wait_cyc(t + 7); start_a = 1'b0;
    wait_cyc(t + 8);
    check("A_no_restart_busy", a_busy, 0);
    wait_cyc(t + 10);

    // Error injection on beat 2 (both l[2] bit 0 and i corrupted)
    t = cyc;
    push_done(1, t + 8, 1);
    inj = 1'b1; seed_b = 8'h40; start_b = 1'b1;
    wait_cyc(t + 1); start_b = 1'b0;
    wait_cyc(t + 2); start_b = 1'b1;
    wait_cyc(t + 3); start_b = 1'b0;
    wait_cyc(t + 8); start_b = 1'b1;
    wait_cyc(t + 9); start_b = 1'b0;
    wait_cyc(t + 11);
    check("B_err_held", b_err, 1);
    check("B_no_restart_busy", b_busy, 0);

    // Fresh B start clears the count; clean run
    t = cyc;
    push_done(1, t + 8, 0);
    inj = 1'b0; seed_b = 8'h33; start_b = 1'b1;
    wait_cyc(t + 1); start_b = 1'b0;
    wait_cyc(t + 3);
    check("B_err_cleared", b_err, 0);
    wait_cyc(t + 10);

    // Saturation with return tied to zero: every beat mismatches
    t = cyc;
    push_done(2, t + 302, 255);
    seed_c = 8'h00; start_c = 1'b1;
    wait_cyc(t + 1); start_c = 1'b0;
    wait_cyc(t + 12);
    check("C_err_progress", c_err, 10);
    wait_cyc(t + 280);
    check("C_err_sat", c_err, 255);
    wait_cyc(t + 305);
    check("C_err_hold", c_err, 255);

    // Asynchronous reset during beat 2 of DUT A
    t = cyc;
    push_beats(8'h20, t, 3);
    seed_a = 8'h20; start_a = 1'b1;
    wait_cyc(t + 1); start_a = 1'b0;
    wait_cyc(t + 3);
    #1 rst_a_n = 1'b0;
    #1;
    check("arst_e", a_e, 0);
    check("arst_f", a_f, 0);
    check("arst_g", a_g, 0);
    check("arst_h", {a_h[0], a_h[1], a_h[2]}, 0);
    check("arst_busy", a_busy, 0);
    check("arst_done", a_done, 0);
    check("arst_err", a_err, 0);
    wait_cyc(t + 5);
    rst_a_n = 1'b1;
    wait_cyc(t + 16);
    check("arst_idle_busy", a_busy, 0);

    // Fresh start after reset
    t = cyc;
    push_beats(8'h20, t, 4);
    push_done(0, t + 6, 0);
    seed_a = 8'h20; start_a = 1'b1;
    wait_cyc(t + 1); start_a = 1'b0;
    wait_cyc(t + 10);

    check("qa_empty", qa.size(), 0);
    check("qda_empty", qda.size(), 0);
    check("qdb_empty", qdb.size(), 0);
    check("qdc_empty", qdc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
